uart_tx_arbiter: RTL

Packet-granular round-robin arbiter that shares the single UART transmit byte stream of the Nios system between several on-chip requesters (GPS parser echo, photobooth status, debug console). Each requester presents bytes on a valid/ready interface with an end-of-packet flag. The arbiter locks the grant for a whole packet and forwards bytes to the UART TX byte port. Watchdogs force release if a requester overruns a length limit or stalls mid-packet.

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX packet arbiter and its round-robin picker.
package uart_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_MAX_BEATS = 64;
  localparam int DEF_IDLE_TO   = 255;

  localparam int GRANT_W = $clog2(DEF_NUM_REQ);
  localparam int BEAT_W  = $clog2(DEF_MAX_BEATS + 1);
  localparam int IDLE_W  = $clog2(DEF_IDLE_TO + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_t;

  // Folds an index in the range [0, 2n) back into [0, n).
  function automatic int rrWrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx
);

  logic [W-1:0] w_cand;

  // Scan from the farthest offset down to zero so the nearest requester after rr_ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = W'(rrWrap(int'(rr_ptr) + k, N));
      if (req[w_cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the UART TX byte stream between requesters.
// The grant is locked for a whole packet; beat-count and idle watchdogs force a release.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int IDLE_TO   = DEF_IDLE_TO
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_valid,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        abort_pulse
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int IW = $clog2(IDLE_TO + 1);

  arb_state_t      r_state;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   r_rr_ptr;
  logic [BW-1:0]   r_beat_cnt;
  logic [IW-1:0]   r_idle_cnt;
  logic            r_abort;

  logic            w_gnt_valid;
  logic [GW-1:0]   w_gnt_idx;
  logic            w_busy;
  logic            w_gvalid;
  logic            w_glast;
  logic            w_beat;
  logic [GW-1:0]   w_next_ptr;

  rr_arbiter #(
    .N (NUM_REQ),
    .W (GW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  // Steer the granted requester onto the TX port; nothing is forwarded while idle.
  always_comb begin
    w_busy     = (r_state == STREAM);
    w_gvalid   = req_valid[r_grant_id];
    w_glast    = req_last[r_grant_id];
    tx_valid   = w_busy & w_gvalid;
    tx_data    = w_busy ? req_data[r_grant_id*DATA_W +: DATA_W] : '0;
    req_ready  = '0;
    if (w_busy) begin
      req_ready[r_grant_id] = tx_ready;
    end
    w_beat     = tx_valid & tx_ready;
    w_next_ptr = GW'(rrWrap(int'(r_grant_id) + 1, NUM_REQ));
  end

  // Arbitration FSM with both watchdogs; abort_pulse is registered so it lands in the bubble cycle.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_idle_cnt <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_grant_id <= w_gnt_idx;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
            r_state    <= STREAM;
          end
        end
        STREAM: begin
          if (w_beat) begin
            r_idle_cnt <= '0;
            if (w_glast) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_next_ptr;
            end else if (r_beat_cnt == BW'(MAX_BEATS - 1)) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_next_ptr;
              r_abort  <= 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end else if (!w_gvalid) begin
            if (r_idle_cnt == IW'(IDLE_TO - 1)) begin
              r_state  <= IDLE;
              r_rr_ptr <= w_next_ptr;
              r_abort  <= 1'b1;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
          end else begin
            r_idle_cnt <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_id    = r_grant_id;
  assign busy        = w_busy;
  assign abort_pulse = r_abort;

endmodule
